// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue R-type controller wrapped around a combinational ALU.
// Each accepted instruction goes through IDLE -> READ -> EXEC -> WB. Opcodes that are
// not R-type skip READ and EXEC and complete in WB with error_o set.
//
// Handshake: a transfer on the instruction port happens at a rising clk_i edge where
// instr_valid_i and instr_ready_o are both 1. instr_ready_o is 1 only in IDLE.
// instr_valid_i and instr_i are ignored in every other cycle, and the producer may
// keep instr_valid_i high while the controller is busy.
module alu_issue_ctrl #(
    parameter int REGISTER_SIZE = 32,
    parameter int REG_COUNT     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              instr_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    output logic [REGISTER_SIZE-1:0] alu_data1_o,
    output logic [REGISTER_SIZE-1:0] alu_data2_o,
    output logic [6:0]               alu_opcode_o,
    output logic [2:0]               alu_func3_o,
    output logic [6:0]               alu_func7_o,
    input  logic [REGISTER_SIZE-1:0] alu_result_i,
    input  logic                     alu_error_i,
    output logic                     done_o,
    output logic                     error_o,
    output logic [31:0]              retired_count_o,
    input  logic [4:0]               dbg_addr_i,
    output logic [REGISTER_SIZE-1:0] dbg_data_o,
    output logic [1:0]               dbg_state_o
);

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [6:0]               opcode_q;
    logic [4:0]               rd_q;
    logic [2:0]               func3_q;
    logic [4:0]               rs1_q;
    logic [4:0]               rs2_q;
    logic [6:0]               func7_q;
    logic                     illegal_q;
    logic [REGISTER_SIZE-1:0] data1_q;
    logic [REGISTER_SIZE-1:0] data2_q;
    logic [REGISTER_SIZE-1:0] result_q;
    logic                     alu_err_q;
    logic [31:0]              retired_q;
    logic [REGISTER_SIZE-1:0] rf [REG_COUNT];

    logic handshake;
    logic wb_err;
    logic wb_commit;

    assign handshake = instr_valid_i && (state_q == S_IDLE);
    assign wb_err    = illegal_q || alu_err_q;
    assign wb_commit = (state_q == S_WB) && !wb_err;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: illegal opcodes jump straight to writeback to report the error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = (instr_i[6:0] == OPC_RTYPE) ? S_READ : S_WB;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the decoded fields on accept; the ALU error capture is cleared so an
    // illegal instruction never reports a stale error from the previous one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q  <= '0;
            rd_q      <= '0;
            func3_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            func7_q   <= '0;
            illegal_q <= 1'b0;
        end else if (handshake) begin
            opcode_q  <= instr_i[6:0];
            rd_q      <= instr_i[11:7];
            func3_q   <= instr_i[14:12];
            rs1_q     <= instr_i[19:15];
            rs2_q     <= instr_i[24:20];
            func7_q   <= instr_i[31:25];
            illegal_q <= (instr_i[6:0] != OPC_RTYPE);
        end
    end

    // Operand read in READ; the registered operands hold steady through EXEC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data1_q <= '0;
            data2_q <= '0;
        end else if (state_q == S_READ) begin
            data1_q <= (rs1_q == 5'd0) ? '0 : rf[rs1_q];
            data2_q <= (rs2_q == 5'd0) ? '0 : rf[rs2_q];
        end
    end

    // Capture the ALU response at the end of EXEC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q  <= '0;
            alu_err_q <= 1'b0;
        end else if (handshake) begin
            alu_err_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            result_q  <= alu_result_i;
            alu_err_q <= alu_error_i;
        end
    end

    // Register file writeback; x0 is never written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_commit && (rd_q != 5'd0)) begin
            rf[rd_q] <= result_q;
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_q <= '0;
        end else if (wb_commit) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign instr_ready_o   = (state_q == S_IDLE);
    assign done_o          = (state_q == S_WB);
    assign error_o         = (state_q == S_WB) && wb_err;
    assign retired_count_o = retired_q;
    assign dbg_state_o     = state_q;

    assign alu_data1_o  = data1_q;
    assign alu_data2_o  = data2_q;
    assign alu_opcode_o = opcode_q;
    assign alu_func3_o  = func3_q;
    assign alu_func7_o  = func7_q;

    assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : rf[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a simple adder-style ALU stub:
// result = data1 + data2 + stub_bias, error = stub_err.
module tb_alu_issue_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [6:0]  alu_opcode_o;
    logic [2:0]  alu_func3_o;
    logic [6:0]  alu_func7_o;
    logic [31:0] alu_result_i;
    logic        alu_error_i;
    logic        done_o;
    logic        error_o;
    logic [31:0] retired_count_o;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_o;
    logic [1:0]  dbg_state_o;

    logic [31:0] stub_bias;
    logic        stub_err;

    int n_total;
    int n_pass;

    alu_issue_ctrl #(.REGISTER_SIZE(32), .REG_COUNT(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_i         (instr_i),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .alu_data1_o     (alu_data1_o),
        .alu_data2_o     (alu_data2_o),
        .alu_opcode_o    (alu_opcode_o),
        .alu_func3_o     (alu_func3_o),
        .alu_func7_o     (alu_func7_o),
        .alu_result_i    (alu_result_i),
        .alu_error_i     (alu_error_i),
        .done_o          (done_o),
        .error_o         (error_o),
        .retired_count_o (retired_count_o),
        .dbg_addr_i      (dbg_addr_i),
        .dbg_data_o      (dbg_data_o),
        .dbg_state_o     (dbg_state_o)
    );

    assign alu_result_i = alu_data1_o + alu_data2_o + stub_bias;
    assign alu_error_i  = stub_err;

    // Clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Driver: one handshake, then observe six cycles. lat = cycles from handshake to done_o
    // (-1 if never), stray = done_o held too long or error_o without done_o.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] bias, input logic err,
                             output logic [31:0] d1, output logic [31:0] d2, output logic [6:0] opc,
                             output logic [2:0] f3, output logic [6:0] f7,
                             output int lat, output logic e, output logic stray);
        @(negedge clk_i);
        instr_i       = instr;
        instr_valid_i = 1'b1;
        stub_bias     = bias;
        stub_err      = err;
        d1 = '0; d2 = '0; opc = '0; f3 = '0; f7 = '0;
        lat = -1; e = 1'b0; stray = 1'b0;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            if (c == 2) begin
                d1 = alu_data1_o; d2 = alu_data2_o; opc = alu_opcode_o;
                f3 = alu_func3_o; f7 = alu_func7_o;
            end
            if (error_o && !done_o) stray = 1'b1;
            if (done_o && lat < 0) begin
                lat = c;
                e   = error_o;
            end else if (done_o) begin
                stray = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        instr_valid_i = 1'b0;
        instr_i = '0;
        stub_bias = '0;
        stub_err = 1'b0;
        dbg_addr_i = '0;
        repeat (3) @(negedge clk_i);
        n_total++;
        if ({done_o, error_o, alu_opcode_o, alu_data1_o, alu_data2_o} !== '0) begin
            $display("FAIL reset_outputs: done=%b err=%b opc=%h d1=%h d2=%h, all must be 0",
                     done_o, error_o, alu_opcode_o, alu_data1_o, alu_data2_o);
        end else n_pass++;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (instr_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", instr_ready_o);
        else n_pass++;
        n_total++;
        if (retired_count_o !== 32'd0) $display("FAIL reset_count: got %h expected 0", retired_count_o);
        else n_pass++;
        n_total++;
        if (dbg_state_o !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state_o);
        else n_pass++;
        for (int a = 0; a < 32; a++) begin
            dbg_addr_i = a[4:0];
            #1;
            n_total++;
            if (dbg_data_o !== 32'd0) $display("FAIL reset_rf[%0d]: got %h expected 0", a, dbg_data_o);
            else n_pass++;
        end
    endtask

    task automatic test_basic;
        logic [31:0] d1, d2; logic [6:0] opc, f7; logic [2:0] f3; int lat; logic e, s;
        // Preload x1 = 0+0+5, x2 = 0+0+7.
        run_instr(rtype(7'd0, 5'd0, 5'd0, 3'd0, 5'd1), 32'd5, 1'b0, d1, d2, opc, f3, f7, lat, e, s);
        run_instr(rtype(7'd0, 5'd0, 5'd0, 3'd0, 5'd2), 32'd7, 1'b0, d1, d2, opc, f3, f7, lat, e, s);
        dbg_addr_i = 5'd1; #1;
        n_total++;
        if (dbg_data_o !== 32'd5) $display("FAIL preload_x1: got %h expected 5", dbg_data_o);
        else n_pass++;
        // add x3, x1, x2
        run_instr(32'h002081B3, 32'd0, 1'b0, d1, d2, opc, f3, f7, lat, e, s);
        n_total++;
        if (d1 !== 32'd5 || d2 !== 32'd7 || opc !== 7'h33)
            $display("FAIL basic_operands: d1=%h d2=%h opc=%h, required 5 7 33", d1, d2, opc);
        else n_pass++;
        n_total++;
        if (lat !== 3 || e !== 1'b0 || s !== 1'b0)
            $display("FAIL basic_done: lat=%0d err=%b stray=%b, required 3 0 0", lat, e, s);
        else n_pass++;
        dbg_addr_i = 5'd3; #1;
        n_total++;
        if (dbg_data_o !== 32'd12) $display("FAIL basic_rd: got %h expected c", dbg_data_o);
        else n_pass++;
        n_total++;
        if (retired_count_o !== 32'd3) $display("FAIL basic_count: got %0d expected 3", retired_count_o);
        else n_pass++;
    endtask

    task automatic test_illegal;
        logic [31:0] d1, d2; logic [6:0] opc, f7; logic [2:0] f3; int lat; logic e, s;
        // addi-shaped word targeting x3.
        run_instr({12'd1, 5'd1, 3'd0, 5'd3, 7'h13}, 32'd0, 1'b0, d1, d2, opc, f3, f7, lat, e, s);
        n_total++;
        if (lat !== 1 || e !== 1'b1 || s !== 1'b0)
            $display("FAIL illegal_done: lat=%0d err=%b stray=%b, required 1 1 0", lat, e, s);
        else n_pass++;
        dbg_addr_i = 5'd3; #1;
        n_total++;
        if (dbg_data_o !== 32'd12) $display("FAIL illegal_rd: got %h expected c", dbg_data_o);
        else n_pass++;
        n_total++;
        if (retired_count_o !== 32'd3) $display("FAIL illegal_count: got %0d expected 3", retired_count_o);
        else n_pass++;
    endtask

    task automatic test_alu_error;
        logic [31:0] d1, d2; logic [6:0] opc, f7; logic [2:0] f3; int lat; logic e, s;
        run_instr(rtype(7'h20, 5'd1, 5'd1, 3'd5, 5'd3), 32'd0, 1'b1, d1, d2, opc, f3, f7, lat, e, s);
        n_total++;
        if (f3 !== 3'd5 || f7 !== 7'h20 || d1 !== 32'd5 || d2 !== 32'd5)
            $display("FAIL aluerr_fields: f3=%h f7=%h d1=%h d2=%h, required 5 20 5 5", f3, f7, d1, d2);
        else n_pass++;
        n_total++;
        if (lat !== 3 || e !== 1'b1 || s !== 1'b0)
            $display("FAIL aluerr_done: lat=%0d err=%b stray=%b, required 3 1 0", lat, e, s);
        else n_pass++;
        dbg_addr_i = 5'd3; #1;
        n_total++;
        if (dbg_data_o !== 32'd12) $display("FAIL aluerr_rd: got %h expected c", dbg_data_o);
        else n_pass++;
        n_total++;
        if (retired_count_o !== 32'd3) $display("FAIL aluerr_count: got %0d expected 3", retired_count_o);
        else n_pass++;
        // Legal instruction to x0: retires, but x0 stays zero.
        run_instr(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd0), 32'd0, 1'b0, d1, d2, opc, f3, f7, lat, e, s);
        n_total++;
        if (lat !== 3 || e !== 1'b0) $display("FAIL x0_done: lat=%0d err=%b, required 3 0", lat, e);
        else n_pass++;
        dbg_addr_i = 5'd0; #1;
        n_total++;
        if (dbg_data_o !== 32'd0) $display("FAIL x0_value: got %h expected 0", dbg_data_o);
        else n_pass++;
        n_total++;
        if (retired_count_o !== 32'd4) $display("FAIL x0_count: got %0d expected 4", retired_count_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int accepts;
        int acc_at [2];
        int dones;
        logic [31:0] b_d1;
        accepts = 0; dones = 0; b_d1 = '0;
        acc_at[0] = -1; acc_at[1] = -1;
        stub_bias = '0; stub_err = 1'b0;
        @(negedge clk_i);
        // A: x4 = x3 + x1 = 17. B: x5 = x4 + x2 = 24.
        instr_i = rtype(7'd0, 5'd1, 5'd3, 3'd0, 5'd4);
        instr_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (instr_ready_o && instr_valid_i) begin
                if (accepts < 2) acc_at[accepts] = c;
                accepts++;
            end
            if (done_o) dones++;
            if (c == 6) b_d1 = alu_data1_o;
            if (c == 7) instr_valid_i = 1'b0;
            @(posedge clk_i);
            #1;
            instr_i = rtype(7'd0, 5'd2, 5'd4, 3'd0, 5'd5);
            @(negedge clk_i);
        end
        n_total++;
        if (accepts !== 2 || acc_at[0] !== 0 || acc_at[1] !== 4)
            $display("FAIL b2b_accepts: count=%0d at %0d,%0d, required 2 at 0,4", accepts, acc_at[0], acc_at[1]);
        else n_pass++;
        n_total++;
        if (dones !== 2) $display("FAIL b2b_dones: got %0d expected 2", dones);
        else n_pass++;
        n_total++;
        if (b_d1 !== 32'd17) $display("FAIL b2b_forward: got %h expected 11", b_d1);
        else n_pass++;
        dbg_addr_i = 5'd5; #1;
        n_total++;
        if (dbg_data_o !== 32'd24) $display("FAIL b2b_rd: got %h expected 18", dbg_data_o);
        else n_pass++;
        n_total++;
        if (retired_count_o !== 32'd6) $display("FAIL b2b_count: got %0d expected 6", retired_count_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_and_wrap;
        logic [31:0] d1, d2; logic [6:0] opc, f7; logic [2:0] f3; int lat; logic e, s;
        int late_done;
        stub_bias = '0; stub_err = 1'b0;
        @(negedge clk_i);
        instr_i = rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd6);
        instr_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (alu_data1_o !== 32'd5) $display("FAIL midrst_exec_d1: got %h expected 5", alu_data1_o);
        else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if (instr_ready_o !== 1'b1 || done_o !== 1'b0 || alu_data1_o !== 32'd0 || retired_count_o !== 32'd0)
            $display("FAIL midrst_async: ready=%b done=%b d1=%h cnt=%h, required 1 0 0 0",
                     instr_ready_o, done_o, alu_data1_o, retired_count_o);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        late_done = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (done_o) late_done++;
        end
        n_total++;
        if (late_done !== 0) $display("FAIL midrst_no_done: got %0d done cycles expected 0", late_done);
        else n_pass++;
        dbg_addr_i = 5'd6; #1;
        n_total++;
        if (dbg_data_o !== 32'd0) $display("FAIL midrst_rd: got %h expected 0", dbg_data_o);
        else n_pass++;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        run_instr(rtype(7'd0, 5'd0, 5'd0, 3'd0, 5'd7), 32'd3, 1'b0, d1, d2, opc, f3, f7, lat, e, s);
        n_total++;
        if (retired_count_o !== 32'd0) $display("FAIL wrap_count: got %h expected 0", retired_count_o);
        else n_pass++;
        dbg_addr_i = 5'd7; #1;
        n_total++;
        if (dbg_data_o !== 32'd3 || lat !== 3) $display("FAIL wrap_rd: got %h lat %0d, required 3 and 3", dbg_data_o, lat);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_basic();
        test_illegal();
        test_alu_error();
        test_back_to_back();
        test_reset_mid_and_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
